ifu_fetch: RTL and testbench
============================

Name: ifu_fetch

Overview:
- Instruction-fetch stage of the 5-stage MIPS pipeline; owns the PC register and drives a variable-latency instruction-memory req/ack port.
- Presents one fetched instruction per transfer (F_PC, F_instr) to the IF/ID pipeline register, advancing only when the hazard unit's enable is high.
- Applies branch/jump redirects from the D stage with MIPS delay-slot semantics.

Parameters:
- RESET_PC, 32'h0000_3000, PC after reset; must match the IF/ID register reset PC.
- PC_STEP, 4, sequential PC increment in bytes.

Ports:
- clk  in  1  rising-edge clock.
- reset  in  1  asynchronous, active-low reset.
- en  in  1  pipeline advance from the hazard unit; same signal as the IF/ID register enable; 1 = IF/ID captures this cycle.
- redirect_valid  in  1  D stage has a taken branch/jump advancing this cycle.
- redirect_pc  in  32  redirect target; bits [1:0] ignored (forced 00).
- imem_req  out  1  fetch request.
- imem_addr  out  32  fetch address, word aligned.
- imem_ack  in  1  memory returns data this cycle; meaningful only while imem_req=1.
- imem_rdata  in  32  instruction word, valid when imem_req&imem_ack.
- F_PC  out  32  PC of the instruction presented.
- F_instr  out  32  instruction presented; 32'h0 (nop) when F_valid=0.
- F_valid  out  1  presented instruction is real.

Behaviour:
- Registers: pc_q (32), buf_q (32), state (FETCH/HOLD), pend_q (1), pend_pc_q (32).
- Reset asserted (reset=0), asynchronously: pc_q=RESET_PC, buf_q=0, state=FETCH, pend_q=0, imem_req=0, F_PC=RESET_PC, F_instr=0, F_valid=0. imem_req=0 for the whole time reset is low. After release, FETCH issues at RESET_PC on the first cycle.
- FETCH:
  - Outputs: imem_req=1, imem_addr=pc_q, F_valid=0, F_instr=0, F_PC=pc_q.
  - imem_addr is held stable until ack.
  - Ack: buf_q<=imem_rdata, go to HOLD.
  - No ack: stay in FETCH (unbounded wait).
- HOLD:
  - Outputs: imem_req=0, F_valid=1, F_instr=buf_q, F_PC=pc_q.
  - en=0: stay in HOLD; outputs frozen.
  - en=1: instruction is consumed; pc_q<=next_pc, go to FETCH.
- next_pc, priority high to low:
  - redirect_valid this cycle -> {redirect_pc[31:2],2'b00}.
  - pend_q -> pend_pc_q.
  - otherwise pc_q+PC_STEP, modulo 2^32 (32'hFFFF_FFFC wraps to 0).
  - pend_q clears on any consume.
- Delay slot:
  - The instruction consumed in the same cycle as redirect_valid, or the next one consumed after it, is the delay slot and is always delivered.
  - redirect_valid while no instruction is consumed that cycle (state FETCH, or HOLD with en=0): pend_q<=1, pend_pc_q<=target. The current fetch completes as the delay slot.
  - A later redirect_valid before the consume overwrites pend_pc_q (last wins).
- Throughput: 2 cycles per instruction minimum (ack cycle, then consume cycle).
- Reset mid-fetch: the outstanding request is abandoned. Memory shares the same reset, so no stale ack is accepted.
- Never de-assert imem_req in FETCH without ack; imem_addr[1:0] is always 00.

Optional Feature:
- IFU_FETCH_BYPASS_EN.
- Defined, ack bypass: in FETCH with imem_ack=1 and en=1, F_valid=1 and F_instr=imem_rdata combinationally. The instruction is consumed that cycle: pc_q<=next_pc, state stays FETCH, buf_q unused. This gives 1 instruction/cycle with zero-wait memory. Ack with en=0 behaves as base (to HOLD).
- Undefined: base behaviour above; no combinational path from imem_rdata to F_instr.

Test Plan:
- Reset low 3 cycles, then high -> imem_req=0 during reset. First cycle after release: imem_addr=32'h3000, F_valid=0, F_instr=0.
- Zero-wait memory, en=1 -> delivered F_PC sequence 3000,3004,3008 each with its rdata. F_valid pulses every 2nd cycle, or every cycle with IFU_FETCH_BYPASS_EN.
- ack delayed 3 cycles for addr 3004 -> imem_addr stays 3004 and F_valid=0 until ack. Then HOLD with F_instr=rdata.
- HOLD with en=0 for 4 cycles -> F_PC/F_instr frozen, imem_req=0. On en=1, the next fetch is at F_PC+4.
- redirect_valid with redirect_pc=32'h3103 in the consume cycle of 3008 -> next imem_addr=3100. Redirect during FETCH of 300C -> 300C delivered, then fetch at 3100.
- pc_q=32'hFFFF_FFFC consumed -> next imem_addr=0. Reset low mid-FETCH -> outputs return to reset values immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch stage of the 5-stage MIPS pipeline.
// Owns the PC, drives a variable-latency req/ack instruction memory, and
// presents one instruction per transfer to the IF/ID register under the
// hazard unit's enable. Branch/jump redirects from D honour the delay slot.
//
// Optional feature macro: IFU_FETCH_BYPASS_EN
//   defined   : an ack arriving with en=1 is delivered combinationally and
//               consumed in the same cycle (1 instruction/cycle, zero-wait).
//   undefined : every fetch is registered in buf_q first (2 cycles/instr).
module ifu_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_3000,
  parameter logic [31:0] PC_STEP  = 32'd4
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        en,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_ack,
  input  logic [31:0] imem_rdata,
  output logic [31:0] F_PC,
  output logic [31:0] F_instr,
  output logic        F_valid
);

  typedef enum logic {
    FETCH = 1'b0,
    HOLD  = 1'b1
  } state_t;

  state_t      state;
  state_t      state_nxt;

  logic [31:0] pc_q;
  logic [31:0] buf_q;
  logic        pend_q;
  logic [31:0] pend_pc_q;

  logic [31:0] redirect_tgt;
  logic [31:0] next_pc;
  logic        ack_bypass;
  logic        ack_capture;
  logic        consume;

  // Redirect targets are always word aligned; the low two bits are dropped.
  assign redirect_tgt = redirect_pc & 32'hFFFF_FFFC;

`ifdef IFU_FETCH_BYPASS_EN
  // Ack with en=1 in FETCH is handed straight through and consumed.
  // Gated by reset so nothing is presented while reset is asserted.
  assign ack_bypass = reset && (state == FETCH) && imem_ack && en;
`else
  assign ack_bypass = 1'b0;
`endif

  // Ack that is parked in buf_q rather than passed through.
  assign ack_capture = (state == FETCH) && imem_ack && !ack_bypass;

  // An instruction leaves the stage when IF/ID captures it.
  assign consume = ((state == HOLD) && en) || ack_bypass;

  // Next sequential/redirected PC: a live redirect beats a pending one,
  // which beats the sequential increment (wraps modulo 2^32).
  always_comb begin
    next_pc = pc_q + PC_STEP;
    if (redirect_valid) begin
      next_pc = redirect_tgt;
    end else if (pend_q) begin
      next_pc = pend_pc_q;
    end
  end

  // FSM state register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH;
    end else begin
      state <= state_nxt;
    end
  end

  // FSM next-state: wait for ack in FETCH, wait for en in HOLD.
  always_comb begin
    state_nxt = state;
    unique case (state)
      FETCH: if (ack_capture) state_nxt = HOLD;
      HOLD:  if (en)          state_nxt = FETCH;
    endcase
  end

  // FSM outputs: request while fetching, present buf_q while holding.
  always_comb begin
    imem_req  = 1'b0;
    imem_addr = pc_q & 32'hFFFF_FFFC;
    F_PC      = pc_q;
    F_valid   = 1'b0;
    F_instr   = '0;
    unique case (state)
      FETCH: begin
        // Reset low forces the request off even though state reads FETCH.
        imem_req = reset;
        if (ack_bypass) begin
          F_valid = 1'b1;
          F_instr = imem_rdata;
        end
      end
      HOLD: begin
        F_valid = 1'b1;
        F_instr = buf_q;
      end
    endcase
  end

  // PC advances only when the presented instruction is consumed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pc_q <= RESET_PC;
    end else if (consume) begin
      pc_q <= next_pc;
    end
  end

  // Fetched word is parked here until IF/ID takes it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      buf_q <= '0;
    end else if (ack_capture) begin
      buf_q <= imem_rdata;
    end
  end

  // A redirect seen while nothing is consumed is remembered (last one wins)
  // so the in-flight instruction can still be delivered as the delay slot.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pend_q    <= 1'b0;
      pend_pc_q <= '0;
    end else if (consume) begin
      pend_q    <= 1'b0;
    end else if (redirect_valid) begin
      pend_q    <= 1'b1;
      pend_pc_q <= redirect_tgt;
    end
  end

endmodule

// File: tb/tb_ifu_fetch.sv
// Self-checking bench for ifu_fetch: directed scenarios for timing and
// boundary behaviour, plus randomized en/redirect/latency traffic checked by
// a scoreboard of the expected delivered-instruction stream.
module tb_ifu_fetch;

  localparam logic [31:0] RST_PC = 32'h0000_3000;

`ifdef IFU_FETCH_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        en = 1'b0;
  logic        redirect_valid = 1'b0;
  logic [31:0] redirect_pc = '0;
  logic        imem_req;
  logic [31:0] imem_addr;
  logic        imem_ack = 1'b0;
  logic [31:0] imem_rdata;
  logic [31:0] F_PC;
  logic [31:0] F_instr;
  logic        F_valid;

  int unsigned checks = 0;
  int unsigned failures = 0;

  ifu_fetch #(.RESET_PC(RST_PC), .PC_STEP(32'd4)) dut (
    .clk(clk), .reset(reset), .en(en),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .imem_req(imem_req), .imem_addr(imem_addr),
    .imem_ack(imem_ack), .imem_rdata(imem_rdata),
    .F_PC(F_PC), .F_instr(F_instr), .F_valid(F_valid)
  );

  always #5 clk = ~clk;

  // Memory content: a bijective function of the address.
  function automatic logic [31:0] word(input logic [31:0] a);
    return {a[15:0] ^ 16'hC3A5, a[31:16] ^ 16'h1E0F};
  endfunction

  assign imem_rdata = imem_ack ? word(imem_addr) : 32'hDEAD_BEEF;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic fail_now(input string name);
    checks++;
    failures++;
    $display("FAIL %s actual=no-expected-entry t=%0t", name, $time);
  endtask

  // ---------------- scoreboard / reference model ----------------
  // Expected stream: d0 = RESET_PC; after delivering d_k the next one is the
  // last redirect seen since the previous delivery (inclusive of this
  // delivery's cycle), else d_k + 4.
  logic [31:0] exp_q[$];
  bit          win_has = 1'b0;
  logic [31:0] win_tgt = '0;
  logic [31:0] mon_pc;
  int unsigned delivered = 0;

  always @(negedge clk) begin
    #3;
    if (!reset) begin
      check("req_in_reset", {31'd0, imem_req}, 32'd0);
      exp_q.delete();
      exp_q.push_back(RST_PC);
      win_has = 1'b0;
    end else begin
      if (!F_valid) check("nop_when_invalid", F_instr, 32'd0);
      if (redirect_valid) begin
        win_has = 1'b1;
        win_tgt = redirect_pc & 32'hFFFF_FFFC;
      end
      if (F_valid && en) begin
        if (exp_q.size() == 0) begin
          fail_now("deliver_unexpected");
        end else begin
          mon_pc = exp_q.pop_front();
          check("deliver_pc", F_PC, mon_pc);
          check("deliver_instr", F_instr, word(mon_pc));
          exp_q.push_back(win_has ? win_tgt : mon_pc + 32'd4);
          win_has = 1'b0;
          delivered++;
        end
      end
    end
  end

  // ---------------- memory model ----------------
  int unsigned lat_mode = 0;
  bit          force_on = 1'b0;
  logic [31:0] force_addr = '0;
  int unsigned force_lat = 0;
  bit          waiting = 1'b0;
  int unsigned cnt = 0;
  logic [31:0] req_addr = '0;

  always @(negedge clk) begin
    #1;
    if (!reset) begin
      waiting  = 1'b0;
      imem_ack = 1'b0;
    end else begin
      if (imem_ack) waiting = 1'b0;
      imem_ack = 1'b0;
      if (waiting) begin
        check("req_held", {31'd0, imem_req}, 32'd1);
        check("addr_held", imem_addr, req_addr);
      end else if (imem_req) begin
        waiting  = 1'b1;
        req_addr = imem_addr;
        if (force_on && imem_addr == force_addr) cnt = force_lat;
        else if (lat_mode != 0)                  cnt = $urandom_range(0, 3);
        else                                     cnt = 0;
        if (exp_q.size() == 0) fail_now("fetch_unexpected");
        else check("fetch_addr", imem_addr, exp_q[0]);
      end
      if (waiting) begin
        if (cnt == 0) imem_ack = 1'b1;
        else cnt--;
      end
    end
  end

  // ---------------- stimulus helpers ----------------
  task automatic step();
    @(negedge clk);
    #3;
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset = 1'b0; en = 1'b0; redirect_valid = 1'b0; redirect_pc = '0;
    repeat (3) @(negedge clk);
    #3;
    check("rst_req", {31'd0, imem_req}, 32'd0);
    check("rst_valid", {31'd0, F_valid}, 32'd0);
    check("rst_instr", F_instr, 32'd0);
    check("rst_pc", F_PC, RST_PC);
    @(negedge clk);
    reset = 1'b1;
  endtask

  task automatic hold_until_valid();
    @(negedge clk);
    en = 1'b0; redirect_valid = 1'b0;
    #3;
    for (int i = 0; i < 30 && !F_valid; i++) step();
    check("valid_wait", {31'd0, F_valid}, 32'd1);
  endtask

  // Consume the presented instruction (optionally with a redirect), then
  // stop at the following cycle with en low.
  task automatic consume(input bit r, input logic [31:0] tgt);
    @(negedge clk);
    en = 1'b1; redirect_valid = r; redirect_pc = tgt;
    #3;
    check("consume_valid", {31'd0, F_valid}, 32'd1);
    @(negedge clk);
    en = 1'b0; redirect_valid = 1'b0;
    #3;
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog actual=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  logic        exp_v;
  int unsigned n;
  logic [31:0] held_pc;
  logic [31:0] held_instr;

  initial begin
    // Reset, then zero-wait memory with en held high.
    do_reset();
    lat_mode = 0; force_on = 1'b0; en = 1'b1;
    #3;
    check("first_req", {31'd0, imem_req}, 32'd1);
    check("first_addr", imem_addr, RST_PC);
    n = 0;
    for (int i = 0; i < 6; i++) begin
      if (i > 0) step();
      exp_v = BYPASS ? 1'b1 : 1'(i % 2);
      check("valid_pattern", {31'd0, F_valid}, {31'd0, exp_v});
      if (F_valid) begin
        check("seq_pc", F_PC, RST_PC + 32'(4 * n));
        n++;
      end
    end

    // 3-cycle ack delay at 3004, then HOLD frozen with en low.
    do_reset();
    force_on = 1'b1; force_addr = 32'h3004; force_lat = 3;
    hold_until_valid();
    check("pc_3000", F_PC, 32'h3000);
    consume(1'b0, '0);
    check("wait_addr", imem_addr, 32'h3004);
    check("wait_valid", {31'd0, F_valid}, 32'd0);
    repeat (2) begin
      step();
      check("wait_addr", imem_addr, 32'h3004);
      check("wait_req", {31'd0, imem_req}, 32'd1);
      check("wait_valid", {31'd0, F_valid}, 32'd0);
    end
    step();
    check("ack_cycle_valid", {31'd0, F_valid}, 32'd0);
    step();
    check("hold_valid", {31'd0, F_valid}, 32'd1);
    check("hold_pc", F_PC, 32'h3004);
    check("hold_instr", F_instr, word(32'h3004));
    check("hold_req", {31'd0, imem_req}, 32'd0);
    held_pc = F_PC; held_instr = F_instr;
    repeat (4) begin
      step();
      check("frozen_pc", F_PC, held_pc);
      check("frozen_instr", F_instr, held_instr);
      check("frozen_req", {31'd0, imem_req}, 32'd0);
    end
    consume(1'b0, '0);
    check("after_hold_addr", imem_addr, 32'h3008);
    check("after_hold_req", {31'd0, imem_req}, 32'd1);
    force_on = 1'b0;

    // Redirect in the consume cycle of 3008.
    do_reset();
    hold_until_valid();
    consume(1'b0, '0);
    hold_until_valid();
    consume(1'b0, '0);
    hold_until_valid();
    check("pc_3008", F_PC, 32'h3008);
    consume(1'b1, 32'h3103);
    check("redirect_addr", imem_addr, 32'h3100);
    check("redirect_req", {31'd0, imem_req}, 32'd1);

    // Two redirects while 300C is still being fetched: 300C is the delay
    // slot and the later target wins.
    do_reset();
    force_on = 1'b1; force_addr = 32'h300C; force_lat = 2;
    hold_until_valid();
    consume(1'b0, '0);
    hold_until_valid();
    consume(1'b0, '0);
    hold_until_valid();
    consume(1'b0, '0);
    check("slot_fetch_addr", imem_addr, 32'h300C);
    @(negedge clk);
    redirect_valid = 1'b1; redirect_pc = 32'h3200;
    #3;
    check("pend_no_valid", {31'd0, F_valid}, 32'd0);
    @(negedge clk);
    redirect_pc = 32'h3100;
    #3;
    @(negedge clk);
    redirect_valid = 1'b0;
    hold_until_valid();
    check("slot_pc", F_PC, 32'h300C);
    check("slot_instr", F_instr, word(32'h300C));
    consume(1'b0, '0);
    check("pend_target_addr", imem_addr, 32'h3100);
    force_on = 1'b0;

    // Wrap from FFFF_FFFC to 0, then async reset in the middle of a fetch.
    do_reset();
    hold_until_valid();
    consume(1'b1, 32'hFFFF_FFFF);
    check("top_addr", imem_addr, 32'hFFFF_FFFC);
    hold_until_valid();
    check("top_pc", F_PC, 32'hFFFF_FFFC);
    force_on = 1'b1; force_addr = 32'h0; force_lat = 5;
    consume(1'b0, '0);
    check("wrap_addr", imem_addr, 32'h0);
    check("wrap_req", {31'd0, imem_req}, 32'd1);
    @(posedge clk);
    #2;
    check("pre_reset_req", {31'd0, imem_req}, 32'd1);
    reset = 1'b0;
    #1;
    check("async_req", {31'd0, imem_req}, 32'd0);
    check("async_pc", F_PC, RST_PC);
    check("async_valid", {31'd0, F_valid}, 32'd0);
    check("async_instr", F_instr, 32'd0);
    force_on = 1'b0;

    // Randomized traffic against the scoreboard.
    lat_mode = 1;
    do_reset();
    for (int i = 0; i < 3000; i++) begin
      if (i == 1500) do_reset();
      @(negedge clk);
      en = ($urandom_range(0, 99) < 70);
      redirect_valid = ($urandom_range(0, 99) < 12);
      case ($urandom_range(0, 9))
        0:       redirect_pc = 32'hFFFF_FFF0 | 32'($urandom_range(0, 15));
        1, 2, 3: redirect_pc = $urandom;
        default: redirect_pc = 32'h3000 + 32'($urandom_range(0, 255));
      endcase
    end
    @(negedge clk);
    en = 1'b1; redirect_valid = 1'b0;
    repeat (10) step();
    check("progress", {31'd0, delivered > 200}, 32'd1);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
